// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage MIPS pipeline.
//
// Holds the 32x32 register file, decodes the control word, extends the
// immediate, detects load-use hazards and registers everything into the
// ID/EX pipeline register.
//
// Ports:
//   CLK, RESET          clock (posedge) and async active-high reset
//   instruction         instruction from IF/ID
//   PCPlus4             PC+4 from IF/ID
//   FLUSH               branch taken in EX: insert a bubble into ID/EX
//   RegWrite_W,
//   WriteReg_W,
//   WriteData_W         write-back port into the register file
//   Stall               combinational load-use stall (freeze PC and IF/ID)
//   *_E                 ID/EX pipeline register outputs
//   Illegal_E           unsupported opcode/funct was decoded
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instruction,
  input  logic [31:0] PCPlus4,
  input  logic        FLUSH,
  input  logic        RegWrite_W,
  input  logic [4:0]  WriteReg_W,
  input  logic [31:0] WriteData_W,
  output logic        Stall,
  output logic        RegWrite_E,
  output logic        MemToReg_E,
  output logic        MemRead_E,
  output logic        MemWrite_E,
  output logic        ALUSrc_E,
  output logic        RegDst_E,
  output logic        BranchEq_E,
  output logic        BranchNe_E,
  output logic [3:0]  ALUControl_E,
  output logic [31:0] ReadData1_E,
  output logic [31:0] ReadData2_E,
  output logic [31:0] SignImm_E,
  output logic [4:0]  Shamt_E,
  output logic [4:0]  Rs_E,
  output logic [4:0]  Rt_E,
  output logic [4:0]  Rd_E,
  output logic [31:0] PCPlus4_E,
  output logic        Illegal_E
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic [31:0] rd1, rd2, imm_ext;
  logic        reg_write, mem_to_reg, mem_read, mem_write;
  logic        alu_src, reg_dst, branch_eq, branch_ne, illegal, zero_ext;
  logic [3:0]  alu_ctrl;
  logic        bubble;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];

  // Register file: reg 0 is hard-wired to zero, write-back is bypassed so
  // a same-cycle write is visible to the instruction being decoded.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWrite_W && WriteReg_W != 5'd0) begin
      regs[WriteReg_W] <= WriteData_W;
    end
  end

  function automatic logic [31:0] read_reg(input logic [4:0] idx,
                                           input logic [31:0] stored);
    if (idx == 5'd0)
      return 32'd0;
    else if (RegWrite_W && WriteReg_W == idx)
      return WriteData_W;
    else
      return stored;
  endfunction

  assign rd1 = read_reg(rs, regs[rs]);
  assign rd2 = read_reg(rt, regs[rt]);

  // Control decode
  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    alu_ctrl   = ALU_AND;
    illegal    = 1'b0;
    zero_ext   = 1'b0;
    if (instruction != NOP_INSTR) begin
      unique case (opcode)
        6'h00: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          unique case (funct)
            6'h20, 6'h21: alu_ctrl = ALU_ADD;
            6'h22, 6'h23: alu_ctrl = ALU_SUB;
            6'h24:        alu_ctrl = ALU_AND;
            6'h25:        alu_ctrl = ALU_OR;
            6'h26:        alu_ctrl = ALU_XOR;
            6'h27:        alu_ctrl = ALU_NOR;
            6'h2A:        alu_ctrl = ALU_SLT;
            6'h00:        alu_ctrl = ALU_SLL;
            6'h02:        alu_ctrl = ALU_SRL;
            6'h03:        alu_ctrl = ALU_SRA;
            default: begin
              // Unknown funct: no side effects, just flag it.
              reg_write = 1'b0;
              reg_dst   = 1'b0;
              illegal   = 1'b1;
            end
          endcase
        end
        6'h23: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          mem_read   = 1'b1;
          alu_src    = 1'b1;
          alu_ctrl   = ALU_ADD;
        end
        6'h2B: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          alu_ctrl  = ALU_ADD;
        end
        6'h08, 6'h09: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_ctrl  = ALU_ADD;
        end
        6'h0A: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_ctrl  = ALU_SLT;
        end
        6'h0C: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_ctrl  = ALU_AND;
          zero_ext  = 1'b1;
        end
        6'h0D: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_ctrl  = ALU_OR;
          zero_ext  = 1'b1;
        end
        6'h04: begin
          branch_eq = 1'b1;
          alu_ctrl  = ALU_SUB;
        end
        6'h05: begin
          branch_ne = 1'b1;
          alu_ctrl  = ALU_SUB;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign imm_ext = zero_ext ? {16'h0000, instruction[15:0]}
                            : {{16{instruction[15]}}, instruction[15:0]};

  // Load-use hazard: conservatively compares both source fields.
  assign Stall  = MemRead_E && (Rt_E != 5'd0) && (Rt_E == rs || Rt_E == rt);
  assign bubble = FLUSH || Stall;

  // ID/EX pipeline register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || bubble) begin
      RegWrite_E   <= 1'b0;
      MemToReg_E   <= 1'b0;
      MemRead_E    <= 1'b0;
      MemWrite_E   <= 1'b0;
      ALUSrc_E     <= 1'b0;
      RegDst_E     <= 1'b0;
      BranchEq_E   <= 1'b0;
      BranchNe_E   <= 1'b0;
      ALUControl_E <= 4'd0;
      ReadData1_E  <= 32'd0;
      ReadData2_E  <= 32'd0;
      SignImm_E    <= 32'd0;
      Shamt_E      <= 5'd0;
      Rs_E         <= 5'd0;
      Rt_E         <= 5'd0;
      Rd_E         <= 5'd0;
      PCPlus4_E    <= 32'd0;
      Illegal_E    <= 1'b0;
    end else begin
      RegWrite_E   <= reg_write;
      MemToReg_E   <= mem_to_reg;
      MemRead_E    <= mem_read;
      MemWrite_E   <= mem_write;
      ALUSrc_E     <= alu_src;
      RegDst_E     <= reg_dst;
      BranchEq_E   <= branch_eq;
      BranchNe_E   <= branch_ne;
      ALUControl_E <= alu_ctrl;
      ReadData1_E  <= rd1;
      ReadData2_E  <= rd2;
      SignImm_E    <= imm_ext;
      Shamt_E      <= instruction[10:6];
      Rs_E         <= rs;
      Rt_E         <= rt;
      Rd_E         <= instruction[15:11];
      PCPlus4_E    <= PCPlus4;
      Illegal_E    <= illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a behavioural model of the ID/EX register and the
// register file, one per-cycle compare process, plus directed literal checks.
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] instruction, PCPlus4, WriteData_W;
  logic        FLUSH, RegWrite_W;
  logic [4:0]  WriteReg_W;
  logic        Stall;
  logic        RegWrite_E, MemToReg_E, MemRead_E, MemWrite_E;
  logic        ALUSrc_E, RegDst_E, BranchEq_E, BranchNe_E, Illegal_E;
  logic [3:0]  ALUControl_E;
  logic [31:0] ReadData1_E, ReadData2_E, SignImm_E, PCPlus4_E;
  logic [4:0]  Shamt_E, Rs_E, Rt_E, Rd_E;

  id_stage dut (
    .CLK(CLK), .RESET(RESET), .instruction(instruction), .PCPlus4(PCPlus4),
    .FLUSH(FLUSH), .RegWrite_W(RegWrite_W), .WriteReg_W(WriteReg_W),
    .WriteData_W(WriteData_W), .Stall(Stall), .RegWrite_E(RegWrite_E),
    .MemToReg_E(MemToReg_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .ALUSrc_E(ALUSrc_E), .RegDst_E(RegDst_E), .BranchEq_E(BranchEq_E),
    .BranchNe_E(BranchNe_E), .ALUControl_E(ALUControl_E),
    .ReadData1_E(ReadData1_E), .ReadData2_E(ReadData2_E),
    .SignImm_E(SignImm_E), .Shamt_E(Shamt_E), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .Rd_E(Rd_E), .PCPlus4_E(PCPlus4_E), .Illegal_E(Illegal_E)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  ctl;   // RegWrite MemToReg MemRead MemWrite ALUSrc RegDst BEq BNe
    logic [3:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  sh, rs, rt, rd;
    logic [31:0] pc;
    logic        ill;
  } ex_t;

  ex_t dut_e;
  assign dut_e = {RegWrite_E, MemToReg_E, MemRead_E, MemWrite_E, ALUSrc_E,
                  RegDst_E, BranchEq_E, BranchNe_E, ALUControl_E,
                  ReadData1_E, ReadData2_E, SignImm_E, Shamt_E, Rs_E, Rt_E,
                  Rd_E, PCPlus4_E, Illegal_E};

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [32];
  ex_t mexp;

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (RegWrite_W && WriteReg_W == idx) return WriteData_W;
    return mregs[idx];
  endfunction

  // Instruction semantics as a table: {ctl flags, ALU op, illegal, zero-ext}.
  function automatic ex_t model_dec(input logic [31:0] ins, input logic [31:0] pc);
    ex_t e;
    logic [13:0] t;
    t = {8'h00, 4'h0, 1'b1, 1'b0};
    if (ins == 32'h0) t = 14'd0;
    else case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20, 6'h21: t = {8'b1000_0100, 4'h2, 2'b00};
        6'h22, 6'h23: t = {8'b1000_0100, 4'h6, 2'b00};
        6'h24: t = {8'b1000_0100, 4'h0, 2'b00};
        6'h25: t = {8'b1000_0100, 4'h1, 2'b00};
        6'h26: t = {8'b1000_0100, 4'h3, 2'b00};
        6'h27: t = {8'b1000_0100, 4'hC, 2'b00};
        6'h2A: t = {8'b1000_0100, 4'h7, 2'b00};
        6'h00: t = {8'b1000_0100, 4'h8, 2'b00};
        6'h02: t = {8'b1000_0100, 4'h9, 2'b00};
        6'h03: t = {8'b1000_0100, 4'hA, 2'b00};
        default: ;
      endcase
      6'h23: t = {8'b1110_1000, 4'h2, 2'b00};
      6'h2B: t = {8'b0001_1000, 4'h2, 2'b00};
      6'h08, 6'h09: t = {8'b1000_1000, 4'h2, 2'b00};
      6'h0A: t = {8'b1000_1000, 4'h7, 2'b00};
      6'h0C: t = {8'b1000_1000, 4'h0, 2'b01};
      6'h0D: t = {8'b1000_1000, 4'h1, 2'b01};
      6'h04: t = {8'b0000_0010, 4'h6, 2'b00};
      6'h05: t = {8'b0000_0001, 4'h6, 2'b00};
      default: ;
    endcase
    e.ctl = t[13:6];
    e.alu = t[5:2];
    e.ill = t[1];
    e.imm = t[0] ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    e.rd1 = mread(ins[25:21]);
    e.rd2 = mread(ins[20:16]);
    e.sh  = ins[10:6];
    e.rs  = ins[25:21];
    e.rt  = ins[20:16];
    e.rd  = ins[15:11];
    e.pc  = pc;
    return e;
  endfunction

  function automatic logic mstall();
    // mexp.ctl[5] is MemRead
    return mexp.ctl[5] && mexp.rt != 0 &&
           (mexp.rt == instruction[25:21] || mexp.rt == instruction[20:16]);
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mexp = '0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else begin
      if (FLUSH || mstall()) mexp = '0;
      else mexp = model_dec(instruction, PCPlus4);
      if (RegWrite_W && WriteReg_W != 0) mregs[WriteReg_W] = WriteData_W;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      checks++;
      if (dut_e !== mexp) begin
        errors++;
        $display("FAIL model_E t=%0t got=%h exp=%h", $time, dut_e, mexp);
      end
      checks++;
      if (Stall !== mstall()) begin
        errors++;
        $display("FAIL model_stall t=%0t got=%b exp=%b", $time, Stall, mstall());
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ctl_word();
    return {20'd0, RegWrite_E, MemToReg_E, MemRead_E, MemWrite_E, ALUSrc_E,
            RegDst_E, BranchEq_E, BranchNe_E, ALUControl_E};
  endfunction

  logic [31:0] extra [10] = '{32'h01095022, 32'h01095024, 32'h01095025,
                              32'h01095026, 32'h01095027, 32'h0109502A,
                              32'h00095103, 32'h11090003, 32'h15090003,
                              32'h29280005};

  initial begin
    RESET = 1'b1; instruction = 32'h0; PCPlus4 = 32'h0; FLUSH = 1'b0;
    RegWrite_W = 1'b0; WriteReg_W = 5'd0; WriteData_W = 32'h0;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("reset_stall", {31'd0, Stall}, 32'd0);
    chk("reset_ctl", ctl_word(), 32'd0);

    RESET = 1'b0; cyc();
    chk("release_ctl", ctl_word(), 32'd0);
    chk("release_ill", {31'd0, Illegal_E}, 32'd0);
    chk("release_pc", PCPlus4_E, 32'd0);

    // write-back R8, R9, then add $t2,$t0,$t1
    RegWrite_W = 1'b1; WriteReg_W = 5'd8; WriteData_W = 32'h0000_1234; cyc();
    WriteReg_W = 5'd9; WriteData_W = 32'd5; cyc();
    RegWrite_W = 1'b0; instruction = 32'h01095020; PCPlus4 = 32'h100; cyc();
    chk("add_rd1", ReadData1_E, 32'h1234);
    chk("add_rd2", ReadData2_E, 32'd5);
    chk("add_rd", {27'd0, Rd_E}, 32'd10);
    chk("add_ctl", ctl_word(), 32'h0000_0842);
    chk("add_pc", PCPlus4_E, 32'h100);

    // same-cycle bypass, then stored value
    RegWrite_W = 1'b1; WriteReg_W = 5'd8; WriteData_W = 32'hDEADBEEF; cyc();
    chk("bypass_rd1", ReadData1_E, 32'hDEADBEEF);
    RegWrite_W = 1'b0; cyc();
    chk("stored_rd1", ReadData1_E, 32'hDEADBEEF);

    // writes to R0 are ignored
    RegWrite_W = 1'b1; WriteReg_W = 5'd0; WriteData_W = 32'hFFFF_FFFF;
    instruction = 32'h00095020; cyc();
    chk("r0_bypass", ReadData1_E, 32'd0);
    RegWrite_W = 1'b0; cyc();
    chk("r0_stored", ReadData1_E, 32'd0);

    // load-use: lw $t0,4($s0) ; add $t2,$t0,$t1
    instruction = 32'h8E080004; cyc();
    chk("lw_memread", {31'd0, MemRead_E}, 32'd1);
    chk("lw_imm", SignImm_E, 32'd4);
    instruction = 32'h01095020; #1;
    chk("lu_stall", {31'd0, Stall}, 32'd1);
    cyc();
    chk("lu_bubble_rw", {31'd0, RegWrite_E}, 32'd0);
    chk("lu_bubble_mw", {31'd0, MemWrite_E}, 32'd0);
    chk("lu_stall_gone", {31'd0, Stall}, 32'd0);
    cyc();
    chk("lu_add_rs", {27'd0, Rs_E}, 32'd8);
    chk("lu_add_rw", {31'd0, RegWrite_E}, 32'd1);

    // immediate extension
    instruction = 32'h31288000; cyc();
    chk("andi_imm", SignImm_E, 32'h0000_8000);
    instruction = 32'h21288000; cyc();
    chk("addi_imm", SignImm_E, 32'hFFFF_8000);

    // sw then flushed sw
    instruction = 32'hAD090008; cyc();
    chk("sw_mw", {31'd0, MemWrite_E}, 32'd1);
    FLUSH = 1'b1; cyc();
    FLUSH = 1'b0;
    chk("flush_mw", {31'd0, MemWrite_E}, 32'd0);

    // illegal opcode / funct
    instruction = 32'hFC000000; cyc();
    chk("illop_ill", {31'd0, Illegal_E}, 32'd1);
    chk("illop_ctl", ctl_word(), 32'd0);
    instruction = 32'h0000003F; cyc();
    chk("illfn_ill", {31'd0, Illegal_E}, 32'd1);
    chk("illfn_ctl", ctl_word(), 32'd0);

    // remaining decode cases, checked by the model
    for (int i = 0; i < 10; i++) begin
      instruction = extra[i]; PCPlus4 = 32'h200 + 32'(i * 4); cyc();
    end
    chk("sra_shamt", {27'd0, Shamt_E}, 32'd0);  // slti is last; shamt bits of imm 5 are 0
    instruction = 32'h00095103; cyc();
    chk("sra_alu", {28'd0, ALUControl_E}, 32'hA);
    chk("sra_shamt4", {27'd0, Shamt_E}, 32'd4);

    // FLUSH and stall together: one bubble, Stall still high
    instruction = 32'h8E080004; cyc();
    instruction = 32'h01095020; FLUSH = 1'b1; #1;
    chk("fs_stall", {31'd0, Stall}, 32'd1);
    cyc();
    FLUSH = 1'b0;
    chk("fs_bubble", {31'd0, RegWrite_E}, 32'd0);
    cyc();
    chk("fs_add_rw", {31'd0, RegWrite_E}, 32'd1);

    // reset mid-operation
    cyc();
    RESET = 1'b1; #1;
    chk("midrst_ctl", ctl_word(), 32'd0);
    chk("midrst_pc", PCPlus4_E, 32'd0);
    cyc();
    RESET = 1'b0; cyc();
    chk("postrst_rw", {31'd0, RegWrite_E}, 32'd1);
    chk("postrst_rd2", ReadData2_E, 32'd0);
    cyc();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline. Sits between IF_stage (`instruction`, `PCPlus4`) and EX_stage.
- Holds the 32x32 register file, decodes control, and extends the immediate.
- Detects load-use hazards and registers everything into the ID/EX pipeline register on `CLK` posedge.

Parameters:
- NOP_INSTR, 32'h00000000, instruction value treated as a bubble.

Ports:
- CLK  in  1  system clock, posedge.
- RESET  in  1  async active-high reset.
- instruction  in  32  from IF_stage.
- PCPlus4  in  32  from IF_stage.
- FLUSH  in  1  from EX_stage: branch taken, squash ID/EX contents.
- RegWrite_W  in  1  write-back enable.
- WriteReg_W  in  5  write-back register index.
- WriteData_W  in  32  write-back data.
- Stall  out  1  combinational: freeze PC and IF/ID this cycle.
- RegWrite_E, MemToReg_E, MemRead_E, MemWrite_E, ALUSrc_E, RegDst_E, BranchEq_E, BranchNe_E  out  1 each  registered controls.
- ALUControl_E  out  4  registered ALU op.
- ReadData1_E, ReadData2_E  out  32 each  registered rs/rt values.
- SignImm_E  out  32  extended immediate.
- Shamt_E  out  5  instr[10:6].
- Rs_E, Rt_E, Rd_E  out  5 each  register indices.
- PCPlus4_E  out  32  passed through.
- Illegal_E  out  1  unsupported opcode/funct seen.

Behaviour:
- Register file: 32x32, written on posedge when RegWrite_W and WriteReg_W != 0.
  - Reg 0 always reads 0.
  - Reads are combinational with internal bypass: if RegWrite_W and WriteReg_W == the read index (nonzero), return WriteData_W.
  - RESET clears all 32 registers.
- Decode (opcode instr[31:26], funct instr[5:0]):
  - R-type (op 0): RegWrite=1, RegDst=1, ALUSrc=0. Funct mapping:
    - add 20 / addu 21 -> ADD
    - sub 22 / subu 23 -> SUB
    - and 24 -> AND, or 25 -> OR, xor 26 -> XOR, nor 27 -> NOR
    - slt 2A -> SLT
    - sll 00 -> SLL, srl 02 -> SRL, sra 03 -> SRA
  - lw 23h: RegWrite, MemToReg, MemRead, ALUSrc, ADD.
  - sw 2Bh: MemWrite, ALUSrc, ADD.
  - addi 08h / addiu 09h: RegWrite, ALUSrc, ADD.
  - slti 0Ah: RegWrite, ALUSrc, SLT.
  - andi 0Ch: RegWrite, ALUSrc, AND. ori 0Dh: RegWrite, ALUSrc, OR.
  - beq 04h: BranchEq, SUB. bne 05h: BranchNe, SUB.
  - Any other op/funct: all controls 0, Illegal=1.
  - Instruction == NOP_INSTR: all controls 0, Illegal=0.
- ALUControl encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, NOR 1100.
- SignImm: zero-extend instr[15:0] for andi/ori; sign-extend for all other opcodes.
- Hazard detection, combinational:
  - Stall = MemRead_E && Rt_E != 0 && (Rt_E == instr[25:21] || Rt_E == instr[20:16]).
  - Conservative: compares both fields regardless of instruction type.
- ID/EX register update on posedge CLK, priority order:
  1. RESET (async): every output register = 0, including PCPlus4_E, data and indices.
  2. FLUSH: all control bits (RegWrite..BranchNe, Illegal) = 0 and ALUControl = 0; data fields don't-care but implemented as 0.
  3. Stall: same bubble as FLUSH. IF/ID is held upstream, so the same instruction re-decodes next cycle.
  4. Otherwise: load the decoded values.
- Latency: 1 cycle from `instruction` to *_E outputs; a stall adds exactly 1 bubble per load-use.
- Stall is 0 during RESET, since MemRead_E = 0.
- FLUSH and Stall in the same cycle: a single bubble is inserted. Stall still asserts so IF holds; EX's flush of IF/ID is upstream's responsibility.
- Simultaneous WB write and read of the same register: bypass returns the new data in the same cycle.
- RESET mid-operation: immediate clear; first posedge after deassert decodes the current input.

Test Plan:
- RESET high, then release with instruction=0 -> all *_E = 0, Stall=0, Illegal_E=0.
- WB writes R8=32'h0000_1234, then add $t2,$t0,$t1 (32'h01095020) with R9=5 -> next cycle ReadData1_E=1234h, ReadData2_E=5, Rd_E=10, ALUControl_E=0010, RegWrite_E=1, RegDst_E=1.
- Same-cycle bypass: RegWrite_W=1, WriteReg_W=8, WriteData_W=32'hDEADBEEF while decoding an instr with rs=8 -> ReadData1_E=DEADBEEF. Write to R0 -> R0 still reads 0.
- lw $t0,4($s0) followed by add using $t0 -> Stall=1 for exactly one cycle, one bubble (RegWrite_E=0, MemWrite_E=0), then add decoded with Rs_E=8.
- andi imm 16'h8000 -> SignImm_E=32'h0000_8000; addi imm 16'h8000 -> SignImm_E=32'hFFFF_8000.
- FLUSH=1 with valid sw decoded -> MemWrite_E=0 next cycle. Opcode 3Fh -> Illegal_E=1 with all controls 0.
